// File: rtl/serial_adder_pkg.sv
// Shared types and opcodes for the bit-serial add/subtract engine.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell; the only arithmetic element of the serial engine.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first,
// one bit per clock, with a start/ready request side and a done pulse on completion.
//
// state  | meaning
// S_IDLE | ready for a request; operands loaded on start
// S_RUN  | one operand bit per edge through the adder cell
// S_DONE | one-cycle done pulse; result registers valid
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fullAdder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at load and seed the carry with 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= (sub == OP_SUB) ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
                    carry <= fa_cout;
                    if (last_bit) begin
                        sum  <= {fa_sum, s_sh[WIDTH-1:1]};
                        cout <= fa_cout;
                        ovf  <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and exhaustive checks of serial_adder_ctrl at WIDTH=8 and WIDTH=4,
// with expected results queued at request time and compared on done.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       ready8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       reset4;
    logic       start4, sub4;
    logic [3:0] a4, b4;
    logic       ready4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int total = 0;
    int bad   = 0;

    // expected entries packed as {ovf, cout, sum}
    logic [9:0] sb8[$];
    logic [9:0] sb4[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .ready (ready8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .ready (ready4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_model(input int w, input int av, input int bv, input bit s);
        int  mask;
        int  bb;
        int  full;
        int  r;
        bit  co, am, bm, rm, ov;
        mask = (1 << w) - 1;
        bb   = s ? (~bv & mask) : bv;
        full = av + bb + (s ? 1 : 0);
        r    = full & mask;
        co   = full[w];
        am   = av[w-1];
        bm   = bv[w-1];
        rm   = r[w-1];
        ov   = s ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
        return {ov, co, r[7:0]};
    endfunction

    task automatic pop8(input string tag);
        logic [9:0] e;
        if (sb8.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb8.pop_front();
            chk({tag, "_sum"},  {24'd0, sum8}, {24'd0, e[7:0]});
            chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, e[8]});
            chk({tag, "_ovf"},  {31'd0, ovf8}, {31'd0, e[9]});
        end
    endtask

    // One WIDTH=8 operation with cycle-exact checks; optional ignored start pulses
    // at RUN cycle glitch_n and in the done cycle.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic [9:0] exp,
                       input int glitch_n, input bit glitch_done);
        @(negedge clk);
        chk({tag, "_ready_pre"}, {31'd0, ready8}, 32'd1);
        a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
        sb8.push_back(exp);
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n <= 8) begin
                chk({tag, "_done_run"},  {31'd0, done8},  32'd0);
                chk({tag, "_ready_run"}, {31'd0, ready8}, 32'd0);
            end else if (n == 9) begin
                chk({tag, "_done"},       {31'd0, done8},  32'd1);
                chk({tag, "_ready_done"}, {31'd0, ready8}, 32'd0);
                pop8(tag);
            end else begin
                chk({tag, "_done_after"},  {31'd0, done8},  32'd0);
                chk({tag, "_ready_after"}, {31'd0, ready8}, 32'd1);
            end
            start8 = (n == glitch_n) || (glitch_done && n == 9);
            if (start8) begin
                a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            end
        end
    endtask

    task automatic op4(input int av, input int bv, input bit s);
        bit seen;
        logic [9:0] e;
        @(negedge clk);
        a4 = 4'(av); b4 = 4'(bv); sub4 = s; start4 = 1'b1;
        sb4.push_back(ref_model(4, av, bv, s));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1'b1;
                e = sb4.pop_front();
                total++;
                assert ({ovf4, cout4, sum4} === {e[9], e[8], e[3:0]}) else begin
                    bad++;
                    $error("FAIL w4 a=%0h b=%0h sub=%0d observed=%0h expected=%0h",
                           av, bv, s, {ovf4, cout4, sum4}, {e[9], e[8], e[3:0]});
                end
            end
        end
        if (!seen) begin
            chk("w4_done_timeout", 32'd0, 32'd1);
            sb4.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, last_done, readys;
        reset = 1'b1; reset4 = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;

        #12;
        chk("rst_ready", {31'd0, ready8}, 32'd1);
        chk("rst_done",  {31'd0, done8},  32'd0);
        chk("rst_sum",   {24'd0, sum8},   32'd0);
        chk("rst_cout",  {31'd0, cout8},  32'd0);
        chk("rst_ovf",   {31'd0, ovf8},   32'd0);
        @(negedge clk);
        reset = 1'b0; reset4 = 1'b0;

        op8("add_05_03", 8'h05, 8'h03, 1'b0, 10'h008, 0, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 10'h100, 0, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 10'h280, 0, 1'b0);
        op8("sub_03_05", 8'h03, 8'h05, 1'b1, 10'h0FE, 0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 10'h37F, 0, 1'b0);

        op8("ignore_start", 8'h10, 8'h20, 1'b0, 10'h030, 3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("hold_sum",  {24'd0, sum8},  32'h30);
            chk("hold_done", {31'd0, done8}, 32'd0);
        end

        // start held high: a new op every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        dones = 0; last_done = -1; readys = 0;
        for (int i = 0; i < 30; i++) begin
            if (ready8) begin
                readys++;
                sb8.push_back(10'h002);
            end
            if (done8) begin
                pop8("stream");
                if (last_done >= 0) begin
                    chk("stream_period", i - last_done, 32'd10);
                    chk("stream_ready_gap", readys, 32'd1);
                end
                last_done = i;
                readys = 0;
                dones++;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        chk("stream_dones", dones, 32'd3);
        chk("stream_sb_empty", sb8.size(), 32'd0);

        // asynchronous abort in the middle of a run
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
        sb8.push_back(10'h0FF);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 2; k <= 4; k++) @(negedge clk);
        chk("abort_ready_pre", {31'd0, ready8}, 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_sum",   {24'd0, sum8},   32'd0);
        chk("abort_cout",  {31'd0, cout8},  32'd0);
        chk("abort_ovf",   {31'd0, ovf8},   32'd0);
        chk("abort_ready", {31'd0, ready8}, 32'd1);
        chk("abort_done",  {31'd0, done8},  32'd0);
        sb8.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done8}, 32'd0);
        end
        op8("after_abort", 8'h0F, 8'h01, 1'b0, 10'h010, 0, 1'b0);

        // exhaustive WIDTH=4 sweep against the reference model
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(x, y, s[0]);
        chk("w4_sb_empty", sb4.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
